// File: rtl/line_window_buffer_pkg.sv
// Shared constants for the 3x3 line window buffer: tap layout and counter sizing.
// Tap k = 3*r + c; r=0 is the oldest line, c=0 is the oldest column.
package line_window_buffer_pkg;

  localparam int WIN_DIM  = 3;
  localparam int WIN_TAPS = WIN_DIM * WIN_DIM;

  localparam int TAP_OLDEST = 0;
  localparam int TAP_CENTER = 4;
  localparam int TAP_NEWEST = 8;

  // Bits needed to count 0..n-1.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/line_buf.sv
// One line of pixel storage: simple dual-port memory, one write and one registered read port.
// Latency: read data appears one cycle after rd_addr; a same-address write returns the old word.
// Backpressure: none, both ports are free-running.
module line_buf #(
  parameter int DEPTH = 256,
  parameter int W     = 8,
  parameter int AW    = 8
) (
  input  logic          CLK,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/line_window_buffer.sv
// Builds a 3x3 sliding window over a raster pixel stream using two line buffers.
// Latency: window is registered one cycle after the pixel completing it is accepted.
// Backpressure: in_ready = !out_valid || out_ready; output holds while stalled.
module line_window_buffer
  import line_window_buffer_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int IMG_W = 256,
  parameter int IMG_H = 256
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic [PIX_W-1:0]          in_data,
  input  logic                      in_valid,
  input  logic                      in_sof,
  output logic                      in_ready,
  output logic [WIN_TAPS*PIX_W-1:0] win_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_sof,
  output logic                      out_eof,
  output logic                      sync_err
);

  localparam int CW = cnt_w(IMG_W);
  localparam int RW = cnt_w(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col_cnt, eff_col, nxt_col, rd_addr;
  logic [RW-1:0] row_cnt, eff_row, nxt_row;
  logic          accept, win_hit;
  logic [PIX_W-1:0] lb1_rd, lb2_rd;
  logic [PIX_W-1:0] new_col [WIN_DIM];
  logic [PIX_W-1:0] hist    [WIN_DIM][2];
  logic [WIN_TAPS*PIX_W-1:0] win_nxt;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // A start-of-frame pixel is always position (0,0), wherever the counters were.
  always_comb begin
    eff_col = in_sof ? '0 : col_cnt;
    eff_row = in_sof ? '0 : row_cnt;
    nxt_col = (eff_col == COL_LAST) ? '0 : eff_col + CW'(1);
    nxt_row = eff_row;
    if (eff_col == COL_LAST) begin
      nxt_row = (eff_row == ROW_LAST) ? '0 : eff_row + RW'(1);
    end
    // Pre-read the column of the next pixel so its line data is ready when it arrives.
    rd_addr = accept ? nxt_col : col_cnt;
    win_hit = (eff_row >= RW'(2)) && (eff_col >= CW'(2));
  end

  line_buf #(.DEPTH(IMG_W), .W(PIX_W), .AW(CW)) u_lb1 (
    .CLK     (CLK),
    .wr_en   (accept),
    .wr_addr (eff_col),
    .wr_data (in_data),
    .rd_addr (rd_addr),
    .rd_data (lb1_rd)
  );

  line_buf #(.DEPTH(IMG_W), .W(PIX_W), .AW(CW)) u_lb2 (
    .CLK     (CLK),
    .wr_en   (accept),
    .wr_addr (eff_col),
    .wr_data (lb1_rd),
    .rd_addr (rd_addr),
    .rd_data (lb2_rd)
  );

  assign new_col[0] = lb2_rd;
  assign new_col[1] = lb1_rd;
  assign new_col[2] = in_data;

  always_comb begin
    win_nxt = '0;
    for (int r = 0; r < WIN_DIM; r++) begin
      for (int c = 0; c < 2; c++) begin
        win_nxt[(WIN_DIM*r + c)*PIX_W +: PIX_W] = hist[r][c];
      end
      win_nxt[(WIN_DIM*r + 2)*PIX_W +: PIX_W] = new_col[r];
    end
  end

  // Column history never needs clearing: windows start at col 2 of each row.
  always_ff @(posedge CLK) begin
    if (accept) begin
      for (int r = 0; r < WIN_DIM; r++) begin
        hist[r][0] <= hist[r][1];
        hist[r][1] <= new_col[r];
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (accept) begin
      col_cnt <= nxt_col;
      row_cnt <= nxt_row;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      win_data  <= '0;
      sync_err  <= 1'b0;
    end else begin
      if (accept) begin
        out_valid <= win_hit;
        if (win_hit) begin
          win_data <= win_nxt;
          out_sof  <= (eff_row == RW'(2)) && (eff_col == CW'(2));
          out_eof  <= (eff_row == ROW_LAST) && (eff_col == COL_LAST);
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept && in_sof && (row_cnt != '0 || col_cnt != '0)) begin
        sync_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/line_window_buffer.md
LINE_WINDOW_BUFFER -- requirements
Module: line_window_buffer

Interface
REQ-001 Parameter PIX_W, default 8: pixel width in bits.
REQ-002 Parameter IMG_W, default 256: pixels per line (>=3).
REQ-003 Parameter IMG_H, default 256: lines per frame (>=3).
REQ-004 CLK  in  1  single clock; all state changes on rising edge.
REQ-005 RESET_N  in  1  asynchronous, active-low reset.
REQ-006 in_data  in  PIX_W  raster-order input pixel.
REQ-007 in_valid  in  1  in_data valid.
REQ-008 in_sof  in  1  marks first pixel of a frame; qualified by in_valid.
REQ-009 in_ready  out  1  block accepts a pixel this cycle.
REQ-010 win_data  out  9*PIX_W  3x3 window; tap k at bits [k*PIX_W +: PIX_W], k = 3*r + c, where r=0 is line n-2, r=2 is current line, c=0 is column m-2, c=2 is current column.
REQ-011 out_valid  out  1  win_data valid.
REQ-012 out_ready  in  1  downstream accepts window.
REQ-013 out_sof  out  1  first window of frame; qualified by out_valid.
REQ-014 out_eof  out  1  last window of frame; qualified by out_valid.
REQ-015 sync_err  out  1  sticky: in_sof seen at a position other than (row 0, col 0).

Function
REQ-016 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-017 in_ready = !out_valid || out_ready, combinationally; no other input stall source.
REQ-018 Column counter 0..IMG_W-1 and row counter 0..IMG_H-1 advance on each input transfer; column wraps to 0 and row increments; after (IMG_H-1, IMG_W-1) both wrap to 0.
REQ-019 Two line buffers of IMG_W entries each hold lines n-1 and n-2; a read and write of the same address in one cycle returns the old data.
REQ-020 A window is produced only for input transfers at row>=2 and col>=2 (valid-only borders): (IMG_W-2)*(IMG_H-2) windows per frame.
REQ-021 Latency: out_valid rises in the cycle after the qualifying input transfer.
REQ-022 While out_valid && !out_ready, win_data, out_sof and out_eof hold stable.
REQ-023 out_sof = 1 for the window at (row 2, col 2); out_eof = 1 for the window at (IMG_H-1, IMG_W-1).
REQ-024 Horizontal window columns do not mix pixels across a line boundary; the first window of each row contains only columns 0..2.
REQ-025 On in_sof at (0,0): normal. On in_sof elsewhere: pixel treated as (0,0), counters restart, sync_err set; no window produced for that pixel; any pending out_valid is still delivered.
REQ-026 in_sof on an accepted pixel at (0,0) at end of previous frame's wrap supports back-to-back frames with zero idle cycles.
REQ-027 Input not accepted when in_valid=0; counters and buffers unchanged.

Reset
REQ-028 RESET_N low asynchronously clears: counters to 0, out_valid, out_sof, out_eof, sync_err to 0, win_data to 0.
REQ-029 Line-buffer contents are not reset; they are not observable before being rewritten.
REQ-030 Reset mid-frame discards the frame; the next accepted pixel is (0,0) regardless of in_sof.

Structure
REQ-031 Shared package holds window tap count (9), tap index constants and counter-width function (clog2).
REQ-032 One sub-module, line_buf: simple dual-port IMG_W x PIX_W memory, synchronous read, inferable as block RAM.

Verification
REQ-033 IMG_W=8, IMG_H=6, pixel=row*16+col, out_ready=1 -> 24 windows; first has taps 00,01,02,10,11,12,20,21,22 with out_sof=1; last has center 0x46, out_eof=1.
REQ-034 Same frame, out_ready low for 5 cycles at window 3 -> in_ready low those 5 cycles, win_data unchanged, no window lost or duplicated.
REQ-035 Two frames back-to-back, second offset by +0x80 -> 48 windows; second frame's first window taps 80..A2, no first-frame data present.
REQ-036 RESET_N low during row 3, then full frame -> all outputs 0 during reset, then 24 correct windows.
REQ-037 in_sof at (2,4) -> sync_err=1 and stays 1; following 48 pixels yield 24 windows identical to REQ-033 pattern.
REQ-038 Random in_valid/out_ready gaps (50%) over 3 frames -> output sequence matches reference-model window list exactly.
